// File: rtl/fn_alu_pipe_if.sv
// Operand/result handshake bundle for fn_alu_pipe: valid/ready on the operand
// side, valid/ready plus result and flags on the result side.
interface fn_alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             carry;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, y, zero, carry
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, y, zero, carry
    );
endinterface

// File: rtl/fn_alu_pipe.sv
// Two-stage valid/ready pipeline applying one of eight ALU functions to two
// unsigned operands, producing a registered result with zero and carry flags.
module fn_alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    fn_alu_pipe_if.slave bus
);
    typedef logic [WIDTH-1:0] word_t;

    // Returns {carry, y}; subtraction's extra bit is the unsigned borrow.
    function automatic logic [WIDTH:0] alu_f(input word_t a, input word_t b,
                                             input logic [2:0] sel);
        logic [WIDTH:0] r;
        case (sel)
            3'd0:    r = {1'b0, a & b};
            3'd1:    r = {1'b0, a | b};
            3'd2:    r = {1'b0, a ^ b};
            3'd3:    r = {1'b0, ~(a ^ b)};
            3'd4:    r = {1'b0, a} + {1'b0, b};
            3'd5:    r = {1'b0, a} - {1'b0, b};
            3'd6:    r = {1'b0, ~(a & b)};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    logic           vld_p1_q, vld_p1_d;
    word_t          a_p1_q, a_p1_d;
    word_t          b_p1_q, b_p1_d;
    logic [2:0]     sel_p1_q, sel_p1_d;
    logic           vld_p2_q, vld_p2_d;
    word_t          y_p2_q, y_p2_d;
    logic           zero_p2_q, zero_p2_d;
    logic           carry_p2_q, carry_p2_d;
    logic           s1_adv, s2_adv;
    logic [WIDTH:0] res_p1;

    assign s2_adv = ~vld_p2_q | bus.out_ready;
    assign s1_adv = ~vld_p1_q | s2_adv;
    assign res_p1 = alu_f(a_p1_q, b_p1_q, sel_p1_q);

    always_comb begin
        vld_p1_d   = vld_p1_q;
        a_p1_d     = a_p1_q;
        b_p1_d     = b_p1_q;
        sel_p1_d   = sel_p1_q;
        vld_p2_d   = vld_p2_q;
        y_p2_d     = y_p2_q;
        zero_p2_d  = zero_p2_q;
        carry_p2_d = carry_p2_q;

        // Stage 1: capture operands; data only changes on an actual load.
        if (s1_adv) begin
            vld_p1_d = bus.in_valid;
            if (bus.in_valid) begin
                a_p1_d   = bus.a;
                b_p1_d   = bus.b;
                sel_p1_d = bus.sel;
            end
        end

        // Stage 2: register result and flags computed from stage 1.
        if (s2_adv) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                y_p2_d     = res_p1[WIDTH-1:0];
                zero_p2_d  = (res_p1[WIDTH-1:0] == '0);
                carry_p2_d = res_p1[WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q   <= 1'b0;
            a_p1_q     <= '0;
            b_p1_q     <= '0;
            sel_p1_q   <= '0;
            vld_p2_q   <= 1'b0;
            y_p2_q     <= '0;
            zero_p2_q  <= 1'b0;
            carry_p2_q <= 1'b0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            a_p1_q     <= a_p1_d;
            b_p1_q     <= b_p1_d;
            sel_p1_q   <= sel_p1_d;
            vld_p2_q   <= vld_p2_d;
            y_p2_q     <= y_p2_d;
            zero_p2_q  <= zero_p2_d;
            carry_p2_q <= carry_p2_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = vld_p2_q;
    assign bus.y         = y_p2_q;
    assign bus.zero      = zero_p2_q;
    assign bus.carry     = carry_p2_q;
endmodule

// File: tb/tb_fn_alu_pipe.sv
// Bench for fn_alu_pipe: vector table, back-pressure and reset sequences,
// randomized scoreboard run at WIDTH=8, and a flag check at WIDTH=16.
module tb_fn_alu_pipe;
    localparam int NTX = 10000;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fn_alu_pipe_if #(.WIDTH(8))  bus8 ();
    fn_alu_pipe_if #(.WIDTH(16)) bus16 ();

    fn_alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    fn_alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [7:0] ey;
        logic       ez;
        logic       ec;
    } vec_t;

    vec_t vec [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on 8-bit values, returns {carry, zero, y}.
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] sel);
        int ia, ib, y, c;
        ia = int'(a);
        ib = int'(b);
        c  = 0;
        case (sel)
            3'd0: y = ia & ib;
            3'd1: y = ia | ib;
            3'd2: y = ia ^ ib;
            3'd3: y = 255 - (ia ^ ib);
            3'd4: begin y = (ia + ib) % 256; c = (ia + ib > 255) ? 1 : 0; end
            3'd5: begin y = (ia - ib + 256) % 256; c = (ia < ib) ? 1 : 0; end
            3'd6: y = 255 - (ia & ib);
            default: y = ia;
        endcase
        return {c[0], (y == 0), y[7:0]};
    endfunction

    function automatic logic [31:0] obs8();
        return 32'({bus8.carry, bus8.zero, bus8.y});
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
        bus8.in_valid = 1'b1;
        bus8.a        = a;
        bus8.b        = b;
        bus8.sel      = sel;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         sent, rcvd, ncyc, nout;
        logic       pending;
        logic [9:0] q [$];
        logic [9:0] exp;
        logic [7:0] t_a [3];
        logic [7:0] t_b [3];
        logic [2:0] t_s [3];

        checks = 0;
        failures = 0;

        vec[0]  = '{8'hC5, 8'h3A, 3'd0, 8'h00, 1'b1, 1'b0};
        vec[1]  = '{8'hC5, 8'h3A, 3'd1, 8'hFF, 1'b0, 1'b0};
        vec[2]  = '{8'hC5, 8'h3A, 3'd2, 8'hFF, 1'b0, 1'b0};
        vec[3]  = '{8'hC5, 8'h3A, 3'd3, 8'h00, 1'b1, 1'b0};
        vec[4]  = '{8'hC5, 8'h3A, 3'd4, 8'hFF, 1'b0, 1'b0};
        vec[5]  = '{8'hC5, 8'h3A, 3'd5, 8'h8B, 1'b0, 1'b0};
        vec[6]  = '{8'hC5, 8'h3A, 3'd6, 8'hFF, 1'b0, 1'b0};
        vec[7]  = '{8'hC5, 8'h3A, 3'd7, 8'hC5, 1'b0, 1'b0};
        vec[8]  = '{8'hFF, 8'h01, 3'd4, 8'h00, 1'b1, 1'b1};
        vec[9]  = '{8'h03, 8'h05, 3'd5, 8'hFE, 1'b0, 1'b1};
        vec[10] = '{8'h05, 8'h05, 3'd5, 8'h00, 1'b1, 1'b0};
        vec[11] = '{8'h80, 8'h80, 3'd4, 8'h00, 1'b1, 1'b1};

        rst_n           = 1'b0;
        bus8.in_valid   = 1'b0;
        bus8.a          = '0;
        bus8.b          = '0;
        bus8.sel        = '0;
        bus8.out_ready  = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.sel       = '0;
        bus16.out_ready = 1'b1;

        // Reset state
        repeat (3) cyc();
        chk("rst_out_valid", 32'(bus8.out_valid), 0);
        chk("rst_flags_y", obs8(), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus8.in_ready), 1);
        cyc();

        // Table: back-to-back, one result per cycle, two edges latency
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) offer(vec[i].a, vec[i].b, vec[i].sel);
            else bus8.in_valid = 1'b0;
            if (i < 12) chk("vec_in_ready", 32'(bus8.in_ready), 1);
            cyc();
            if (i >= 1) begin
                chk($sformatf("vec%0d_valid", i - 1), 32'(bus8.out_valid), 1);
                chk($sformatf("vec%0d_result", i - 1), obs8(),
                    32'({vec[i-1].ec, vec[i-1].ez, vec[i-1].ey}));
            end
        end
        cyc();
        chk("vec_drain_valid", 32'(bus8.out_valid), 0);

        // Back-pressure: three offers with out_ready low
        t_a = '{8'h12, 8'hF0, 8'h10};
        t_b = '{8'h34, 8'h0F, 8'h20};
        t_s = '{3'd2, 3'd4, 3'd5};
        bus8.out_ready = 1'b0;
        offer(t_a[0], t_b[0], t_s[0]);
        @(negedge clk);
        chk("bp_rdy0", 32'(bus8.in_ready), 1);
        cyc();
        offer(t_a[1], t_b[1], t_s[1]);
        @(negedge clk);
        chk("bp_rdy1", 32'(bus8.in_ready), 1);
        cyc();
        offer(t_a[2], t_b[2], t_s[2]);
        @(negedge clk);
        chk("bp_full_rdy", 32'(bus8.in_ready), 0);
        chk("bp_full_valid", 32'(bus8.out_valid), 1);
        chk("bp_hold_y0", obs8(), 32'(ref8(t_a[0], t_b[0], t_s[0])));
        repeat (2) cyc();
        @(negedge clk);
        chk("bp_still_full", 32'(bus8.in_ready), 0);
        chk("bp_hold_y1", obs8(), 32'(ref8(t_a[0], t_b[0], t_s[0])));
        bus8.out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(bus8.in_ready), 1);
        cyc();
        bus8.in_valid = 1'b0;
        chk("bp_out1_valid", 32'(bus8.out_valid), 1);
        chk("bp_out1", obs8(), 32'(ref8(t_a[1], t_b[1], t_s[1])));
        cyc();
        chk("bp_out2_valid", 32'(bus8.out_valid), 1);
        chk("bp_out2", obs8(), 32'(ref8(t_a[2], t_b[2], t_s[2])));
        cyc();
        chk("bp_drained", 32'(bus8.out_valid), 0);

        // Reset with two transactions in flight
        bus8.out_ready = 1'b0;
        offer(8'hC5, 8'h3A, 3'd1);
        cyc();
        offer(8'h5A, 8'h00, 3'd7);
        cyc();
        bus8.in_valid = 1'b0;
        chk("mid_full_valid", 32'(bus8.out_valid), 1);
        chk("mid_full_rdy", 32'(bus8.in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus8.out_valid), 0);
        chk("mid_rst_flags_y", obs8(), 0);
        chk("mid_rst_rdy", 32'(bus8.in_ready), 1);
        repeat (2) cyc();
        rst_n = 1'b1;
        bus8.out_ready = 1'b1;
        nout = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus8.out_valid) nout++;
            cyc();
        end
        chk("mid_no_stale", 32'(nout), 0);
        chk("mid_post_rdy", 32'(bus8.in_ready), 1);

        // Width 16 flag case
        bus16.in_valid = 1'b1;
        bus16.a        = 16'hFFFF;
        bus16.b        = 16'h0001;
        bus16.sel      = 3'd4;
        cyc();
        bus16.in_valid = 1'b0;
        cyc();
        chk("w16_valid", 32'(bus16.out_valid), 1);
        chk("w16_y", 32'(bus16.y), 0);
        chk("w16_carry", 32'(bus16.carry), 1);
        chk("w16_zero", 32'(bus16.zero), 1);

        // Random stress against the scoreboard
        sent = 0;
        rcvd = 0;
        ncyc = 0;
        pending = 1'b0;
        bus8.in_valid = 1'b0;
        while ((rcvd < NTX) && (ncyc < 60000)) begin
            if (!pending) begin
                bus8.a   = 8'($urandom);
                bus8.b   = 8'($urandom);
                bus8.sel = 3'($urandom);
                bus8.in_valid = (sent < NTX) && ($urandom_range(0, 9) < 7);
            end
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus8.in_valid && bus8.in_ready) begin
                q.push_back(ref8(bus8.a, bus8.b, bus8.sel));
                sent++;
                pending = 1'b0;
            end else begin
                pending = bus8.in_valid;
            end
            if (bus8.out_valid && bus8.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stress_extra: output %0h with empty scoreboard at %0t",
                             obs8(), $time);
                end else begin
                    exp = q.pop_front();
                    chk("stress", obs8(), 32'(exp));
                end
                rcvd++;
            end
            cyc();
            ncyc++;
        end
        bus8.in_valid = 1'b0;
        chk("stress_count_in", 32'(sent), NTX);
        chk("stress_count_out", 32'(rcvd), NTX);
        chk("stress_sb_empty", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
